// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle ARM control unit.
//   state_t      - main FSM states
//   ctrl_t       - Moore control bits produced by each FSM state
//   ALU_*        - ALUControl encodings
//   SRCB_*       - ALUSrcB encodings
//   RES_*        - ResultSrc encodings
//   IMM_*        - ImmSrc encodings
//   OP_*         - Instr[27:26] instruction classes
//   CMD_*        - data-processing cmd field Instr[24:21]
//   COND_*       - condition field Instr[31:28]
//   state_ctrl() - Moore output table of the FSM
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_8  = 2'b00;
   localparam logic [1:0] IMM_12 = 2'b01;
   localparam logic [1:0] IMM_24 = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   typedef struct packed {
      logic       ir_write;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
   } ctrl_t;

   // Moore output table; anything not set for a state stays 0.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.adr_src    = 1'b0;
            c.ir_write   = 1'b1;
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
            c.next_pc    = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b0;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_w      = 1'b1;
         end
         S_MEMWRITE: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
            c.mem_w      = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_src_a = 1'b0;
            c.alu_src_b = SRCB_WD;
            c.alu_op    = 1'b1;
         end
         S_EXECUTEI: begin
            c.alu_src_a = 1'b0;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = 1'b1;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_w      = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = 1'b0;
            c.alu_src_b  = SRCB_IMM;
            c.result_src = RES_ALURESULT;
            c.branch     = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: datapath <-> control unit bus.
//   Instr[31:12], ALUFlags     - from datapath to control
//   RegSrc .. ResultSrc        - select/enable bus from control to datapath
//   modport master             - control unit side
//   modport slave              - datapath side
interface mc_control_unit_if;
   logic [31:12] Instr;
   logic [3:0]   ALUFlags;
   logic [1:0]   RegSrc;
   logic         RegWrite;
   logic [1:0]   ImmSrc;
   logic         ALUSrcA;
   logic [1:0]   ALUSrcB;
   logic [1:0]   ALUControl;
   logic         AdrSrc;
   logic         PCWrite;
   logic         IRWrite;
   logic         MemWrite;
   logic [1:0]   ResultSrc;

   modport master (
      input  Instr, ALUFlags,
      output RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
             AdrSrc, PCWrite, IRWrite, MemWrite, ResultSrc
   );

   modport slave (
      output Instr, ALUFlags,
      input  RegSrc, RegWrite, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
             AdrSrc, PCWrite, IRWrite, MemWrite, ResultSrc
   );
endinterface

// File: rtl/cond_logic.sv
// cond_logic: NZCV flags register, condition evaluation and gating of the
// architectural write enables.
//   clk, reset       - clock, async active-high reset
//   cond             - Instr[31:28]
//   alu_flags        - {N,Z,C,V} from the ALU this cycle
//   flag_w           - {NZ, CV} flag write requests from the ALU decoder
//   reg_w, mem_w     - ungated write requests from the FSM
//   branch, next_pc  - branch / PC-increment requests from the FSM
//   rd_is_pc         - destination register is R15
//   reg_write, mem_write, pc_write - gated enables to the datapath
module cond_logic
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   input  logic       reg_w,
   input  logic       mem_w,
   input  logic       branch,
   input  logic       next_pc,
   input  logic       rd_is_pc,
   output logic       reg_write,
   output logic       mem_write,
   output logic       pc_write
);

   logic [1:0] nz_r;
   logic [1:0] cv_r;
   logic       cond_ex_s;
   logic       cond_ex_delayed_r;
   logic       n_s, z_s, c_s, v_s;
   logic       pcs_s;

   assign n_s = nz_r[1];
   assign z_s = nz_r[0];
   assign c_s = cv_r[1];
   assign v_s = cv_r[0];

   // Evaluate the instruction condition against the stored flags
   always_comb begin
      cond_ex_s = 1'b0;
      case (cond)
         COND_EQ: cond_ex_s = z_s;
         COND_NE: cond_ex_s = ~z_s;
         COND_CS: cond_ex_s = c_s;
         COND_CC: cond_ex_s = ~c_s;
         COND_MI: cond_ex_s = n_s;
         COND_PL: cond_ex_s = ~n_s;
         COND_VS: cond_ex_s = v_s;
         COND_VC: cond_ex_s = ~v_s;
         COND_HI: cond_ex_s = c_s & ~z_s;
         COND_LS: cond_ex_s = ~c_s | z_s;
         COND_GE: cond_ex_s = ~(n_s ^ v_s);
         COND_LT: cond_ex_s = n_s ^ v_s;
         COND_GT: cond_ex_s = ~z_s & ~(n_s ^ v_s);
         COND_LE: cond_ex_s = z_s | (n_s ^ v_s);
         COND_AL: cond_ex_s = 1'b1;
         COND_NV: cond_ex_s = 1'b0;
         default: cond_ex_s = 1'b0;
      endcase
   end

   // Flags register: each half loads only when requested and the condition holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz_r <= 2'b00;
         cv_r <= 2'b00;
      end else begin
         if (flag_w[1] & cond_ex_s) begin
            nz_r <= alu_flags[3:2];
         end
         if (flag_w[0] & cond_ex_s) begin
            cv_r <= alu_flags[1:0];
         end
      end
   end

   // Delay CondEx so writeback sees the condition computed before any flag update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cond_ex_delayed_r <= 1'b0;
      end else begin
         cond_ex_delayed_r <= cond_ex_s;
      end
   end

   assign pcs_s     = branch | (reg_w & rd_is_pc);
   assign reg_write = reg_w & cond_ex_delayed_r;
   assign mem_write = mem_w & cond_ex_delayed_r;
   assign pc_write  = next_pc | (pcs_s & cond_ex_delayed_r);

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM control unit (main FSM + ALU decoder +
// conditional-execution logic).
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (forces FETCH, clears flags)
//   bus   - mc_control_unit_if.master: Instr/ALUFlags in, all datapath
//           selects and enables out
// Build option MC_CMP_EN: when defined, cmd 1010 decodes as CMP (sub, no
// register write, FlagW=11 with S); otherwise it is an unsupported cmd.
module mc_control_unit
   import mc_ctrl_pkg::*;
(
   input logic               clk,
   input logic               reset,
   mc_control_unit_if.master bus
);

   state_t     state_r;
   state_t     next_state_s;
   ctrl_t      ctrl_r;
   logic [1:0] op_s;
   logic [5:0] funct_s;
   logic [3:0] cmd_s;
   logic [3:0] cond_s;
   logic [3:0] rd_s;
   logic [1:0] dec_alu_s;
   logic       supported_s;
   logic       is_arith_s;
   logic       no_write_s;
   logic [1:0] flag_w_s;
   logic       reg_w_s;
   logic [1:0] imm_src_s;
   logic       unused_s;

   assign cond_s   = bus.Instr[31:28];
   assign op_s     = bus.Instr[27:26];
   assign funct_s  = bus.Instr[25:20];
   assign rd_s     = bus.Instr[15:12];
   assign cmd_s    = funct_s[4:1];
   assign unused_s = ^bus.Instr[19:16];

   function automatic state_t next_state(input state_t s, input logic [1:0] op,
                                         input logic [5:0] funct);
      state_t n;
      case (s)
         S_FETCH:  n = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_DP:   n = funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_MEM:  n = S_MEMADR;
               OP_BR:   n = S_BRANCH;
               default: n = S_FETCH;
            endcase
         end
         S_MEMADR:   n = funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  n = S_MEMWB;
         S_EXECUTER: n = S_ALUWB;
         S_EXECUTEI: n = S_ALUWB;
         default:    n = S_FETCH;
      endcase
      return n;
   endfunction

   assign next_state_s = next_state(state_r, op_s, funct_s);

   // Main FSM; Moore controls are registered alongside the state from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_FETCH;
         ctrl_r  <= state_ctrl(S_FETCH);
      end else begin
         state_r <= next_state_s;
         ctrl_r  <= state_ctrl(next_state_s);
      end
   end

   // ALU decoder on the cmd field; unsupported cmds fall back to add with no writes
   always_comb begin
      dec_alu_s   = ALU_ADD;
      supported_s = 1'b0;
      is_arith_s  = 1'b0;
      no_write_s  = 1'b0;
      case (cmd_s)
         CMD_ADD: begin
            dec_alu_s   = ALU_ADD;
            supported_s = 1'b1;
            is_arith_s  = 1'b1;
         end
         CMD_SUB: begin
            dec_alu_s   = ALU_SUB;
            supported_s = 1'b1;
            is_arith_s  = 1'b1;
         end
         CMD_AND: begin
            dec_alu_s   = ALU_AND;
            supported_s = 1'b1;
         end
         CMD_ORR: begin
            dec_alu_s   = ALU_ORR;
            supported_s = 1'b1;
         end
`ifdef MC_CMP_EN
         CMD_CMP: begin
            dec_alu_s   = ALU_SUB;
            supported_s = 1'b1;
            is_arith_s  = 1'b1;
            no_write_s  = 1'b1;
         end
`endif
         default: begin
            dec_alu_s   = ALU_ADD;
            supported_s = 1'b0;
         end
      endcase
   end

   // ImmSrc follows the instruction class directly
   always_comb begin
      imm_src_s = IMM_8;
      case (op_s)
         OP_DP:   imm_src_s = IMM_8;
         OP_MEM:  imm_src_s = IMM_12;
         OP_BR:   imm_src_s = IMM_24;
         default: imm_src_s = 2'b11;
      endcase
   end

   assign flag_w_s = ctrl_r.alu_op ?
                     {funct_s[0] & supported_s, funct_s[0] & supported_s & is_arith_s} :
                     2'b00;

   // Instr is held by the IR through writeback, so the decode is still valid in ALUWB.
   assign reg_w_s = ctrl_r.reg_w &
                    ~((state_r == S_ALUWB) & (~supported_s | no_write_s));

   assign bus.RegSrc     = {op_s == OP_MEM, op_s == OP_BR};
   assign bus.ImmSrc     = imm_src_s;
   assign bus.ALUSrcA    = ctrl_r.alu_src_a;
   assign bus.ALUSrcB    = ctrl_r.alu_src_b;
   assign bus.ALUControl = ctrl_r.alu_op ? dec_alu_s : ALU_ADD;
   assign bus.AdrSrc     = ctrl_r.adr_src;
   assign bus.IRWrite    = ctrl_r.ir_write;
   assign bus.ResultSrc  = ctrl_r.result_src;

   cond_logic u_cond (
      .clk       (clk),
      .reset     (reset),
      .cond      (cond_s),
      .alu_flags (bus.ALUFlags),
      .flag_w    (flag_w_s),
      .reg_w     (reg_w_s),
      .mem_w     (ctrl_r.mem_w),
      .branch    (ctrl_r.branch),
      .next_pc   (ctrl_r.next_pc),
      .rd_is_pc  (rd_s == 4'd15),
      .reg_write (bus.RegWrite),
      .mem_write (bus.MemWrite),
      .pc_write  (bus.PCWrite)
   );

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed test-plan steps followed by random instructions,
// each cycle compared against an instruction-level reference model.
module tb_mc_control_unit;

`ifdef MC_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   logic [3:0] mflags;   // model {N,Z,C,V}

   mc_control_unit_if bus ();

   mc_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural condition test: pick the base predicate from cond[3:1], invert on cond[0].
   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (cond == 4'hF) return 1'b0;
      return base ^ cond[0];
   endfunction

   function automatic logic [1:0] dp_alu(input logic [3:0] cmd);
      case (cmd)
         4'h4: return 2'd0;
         4'h2: return 2'd1;
         4'h0: return 2'd2;
         4'hC: return 2'd3;
         4'hA: return CMP_EN ? 2'd1 : 2'd0;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic dp_writes(input logic [3:0] cmd);
      return (cmd == 4'h0) || (cmd == 4'h2) || (cmd == 4'h4) || (cmd == 4'hC);
   endfunction

   function automatic logic dp_sets_nz(input logic [3:0] cmd);
      return dp_writes(cmd) || (CMP_EN && cmd == 4'hA);
   endfunction

   function automatic logic dp_sets_cv(input logic [3:0] cmd);
      return (cmd == 4'h2) || (cmd == 4'h4) || (CMP_EN && cmd == 4'hA);
   endfunction

   function automatic int latency(input logic [31:0] ins);
      case (ins[27:26])
         2'b00: return 4;
         2'b01: return ins[20] ? 5 : 4;
         2'b10: return 3;
         default: return 2;
      endcase
   endfunction

   // Expected {IRWrite,PCWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,RegSrc,ImmSrc}
   function automatic logic [15:0] expect_cycle(input logic [31:0] ins, input int c, input logic pass);
      logic [1:0] op;
      logic [3:0] cmd;
      logic       ir, pc, rw, mw, adr, srca, rd15;
      logic [1:0] srcb, res, aluc;
      op = ins[27:26]; cmd = ins[24:21]; rd15 = (ins[15:12] == 4'hF);
      ir = 0; pc = 0; rw = 0; mw = 0; adr = 0; srca = 0;
      srcb = 2'd0; res = 2'd0; aluc = 2'd0;
      if (c == 1) begin
         ir = 1; pc = 1; srca = 1; srcb = 2'd2; res = 2'd2;
      end else if (c == 2) begin
         srca = 1; srcb = 2'd2; res = 2'd2;
      end else if (op == 2'b00) begin
         if (c == 3) begin
            srcb = ins[25] ? 2'd1 : 2'd0;
            aluc = dp_alu(cmd);
         end else begin
            rw = pass & dp_writes(cmd);
            pc = rw & rd15;
         end
      end else if (op == 2'b01) begin
         if (c == 3) srcb = 2'd1;
         else if (c == 4) begin
            adr = 1; mw = pass & ~ins[20];
         end else begin
            res = 2'd1; rw = pass; pc = pass & rd15;
         end
      end else if (op == 2'b10) begin
         srcb = 2'd1; res = 2'd2; pc = pass;
      end
      return {ir, pc, rw, mw, adr, srca, srcb, res, aluc, (op == 2'b01), (op == 2'b10), op};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc, bus.ALUSrcA,
              bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.RegSrc, bus.ImmSrc};
   endfunction

   task automatic check(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
      end
   endtask

   // Run one instruction from FETCH; flags = -1 means random ALUFlags every cycle.
   task automatic run_instr(input string tag, input logic [31:0] ins, input int flags);
      int         lat;
      logic       pass;
      logic [3:0] ex_flags;
      logic [3:0] cmd;
      lat = latency(ins);
      pass = cond_ok(ins[31:28], mflags);
      ex_flags = 4'h0;
      cmd = ins[24:21];
      for (int c = 1; c <= lat; c++) begin
         bus.Instr = ins[31:12];
         bus.ALUFlags = (flags < 0) ? 4'($urandom_range(0, 15)) : 4'(flags);
         if (c == 3) ex_flags = bus.ALUFlags;
         @(negedge clk);
         check(tag, c, obs_vec(), expect_cycle(ins, c, pass));
         @(posedge clk);
         #1;
      end
      if (ins[27:26] == 2'b00 && pass && ins[20]) begin
         if (dp_sets_nz(cmd)) mflags[3:2] = ex_flags[3:2];
         if (dp_sets_cv(cmd)) mflags[1:0] = ex_flags[1:0];
      end
   endtask

   // Run an instruction and assert reset part-way through cycle 'abort_c'.
   task automatic run_abort(input string tag, input logic [31:0] ins, input int abort_c);
      logic pass;
      pass = cond_ok(ins[31:28], mflags);
      for (int c = 1; c < abort_c; c++) begin
         bus.Instr = ins[31:12];
         bus.ALUFlags = 4'($urandom_range(0, 15));
         @(negedge clk);
         check(tag, c, obs_vec(), expect_cycle(ins, c, pass));
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      check({tag, "_rst"}, abort_c, obs_vec(), expect_cycle(ins, 1, 1'b0));
      @(negedge clk);
      check({tag, "_rsthold"}, abort_c, obs_vec(), expect_cycle(ins, 1, 1'b0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      mflags = 4'h0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [3:0]  cmds [6];
      r = $urandom;
      cmds[0] = 4'h0; cmds[1] = 4'h2; cmds[2] = 4'h4;
      cmds[3] = 4'hC; cmds[4] = 4'hA; cmds[5] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r[31:28] = 4'hE;
      if ($urandom_range(0, 7) == 0) r[15:12] = 4'hF;
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4: begin
            r[27:26] = 2'b00;
            r[24:21] = cmds[$urandom_range(0, 5)];
         end
         5, 6, 7: r[27:26] = 2'b01;
         8:       r[27:26] = 2'b10;
         default: r[27:26] = 2'b11;
      endcase
      return r;
   endfunction

   initial begin
      errors = 0;
      checks = 0;
      mflags = 4'h0;
      reset = 1'b1;
      bus.Instr = 20'h0;
      bus.ALUFlags = 4'h0;
      #2;
      check("reset_hold", 0, obs_vec(), expect_cycle(32'h0, 1, 1'b0));
      bus.Instr = 20'hE5854;
      bus.ALUFlags = 4'hF;
      @(negedge clk);
      check("reset_hold_str", 0, obs_vec(), expect_cycle(32'hE5854008, 1, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_instr("add",      32'hE0821003, -1);
      run_instr("add_pc",   32'hE082F003, -1);
      run_instr("subs_z",   32'hE0500000, 4'b0100);
      run_instr("beq_tk",   32'h0A000002, -1);
      run_instr("subs_nz",  32'hE0500000, 4'b0000);
      run_instr("beq_nt",   32'h0A000002, -1);
      run_instr("ldr",      32'hE5954008, -1);
      run_instr("str",      32'hE5854008, -1);
      run_instr("subs_z2",  32'hE0500000, 4'b0100);
      run_instr("addne",    32'h10821003, -1);
      run_instr("subs_nz2", 32'hE0500000, 4'b0000);
      run_instr("cmp",      32'hE1520003, 4'b0100);
      run_instr("beq_cmp",  32'h0A000002, -1);
      run_instr("nop",      32'hEC000000, -1);
      run_instr("orrs",     32'hE1921003, 4'b1000);
      run_instr("bmi",      32'h4A000002, -1);

      run_instr("subs_z3",  32'hE0500000, 4'b0100);
      run_abort("abort_str", 32'hE5854008, 4);
      run_instr("beq_after_rst", 32'h0A000002, -1);
      run_abort("abort_adds", 32'hE0921003, 4);
      run_instr("bne_after_rst", 32'h1A000002, -1);

      for (int i = 0; i < 300; i++) begin
         run_instr("rand", rand_instr(), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
